// File: rtl/prefetch_line_buffer_pkg.sv
// Shared types and geometry helpers for the prefetch line buffer.
package prefetch_line_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FILL     = 2'd1,
      PREFETCH = 2'd2
   } lb_state_t;

   localparam int WORD_W = 32;

   // Bytes held by one buffered line.
   function automatic int line_bytes(input int line_bits);
      return line_bits / 8;
   endfunction

   // Number of byte-offset bits inside one line.
   function automatic int off_w(input int line_bits);
      return $clog2(line_bits / 8);
   endfunction

endpackage

// File: rtl/prefetch_line_buffer_if.sv
// Fetch-side (ufp) and I-cache-side (dfp) signals of the prefetch line buffer.
interface prefetch_line_buffer_if #(
   parameter int ADDR_W    = 32,
   parameter int LINE_BITS = 256
);
   logic                 flush;
   logic [ADDR_W-1:0]    ufp_addr;
   logic [3:0]           ufp_rmask;
   logic [31:0]          ufp_rdata;
   logic                 ufp_resp;
   logic [ADDR_W-1:0]    dfp_addr;
   logic                 dfp_read;
   logic [LINE_BITS-1:0] dfp_rdata;
   logic                 dfp_resp;

   // Environment side: fetch unit plus downstream I-cache.
   modport master (
      output flush, ufp_addr, ufp_rmask, dfp_rdata, dfp_resp,
      input  ufp_rdata, ufp_resp, dfp_addr, dfp_read
   );

   // Buffer side.
   modport slave (
      input  flush, ufp_addr, ufp_rmask, dfp_rdata, dfp_resp,
      output ufp_rdata, ufp_resp, dfp_addr, dfp_read
   );
endinterface

// File: rtl/prefetch_line_buffer_tag_match.sv
// Fully-associative tag lookup: several lookup ports share one tag/valid
// array; also reports the lowest invalid entry and whether all are valid.
module lb_tag_match
   import prefetch_line_buffer_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int ADDR_W    = 32,
   parameter int NUM_PORTS = 3,
   parameter int IDX_W     = $clog2(NUM_LINES)
) (
   input  logic [NUM_LINES-1:0]             i_valid,
   input  logic [NUM_LINES-1:0][ADDR_W-1:0] i_tags,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0] i_addr,
   output logic [NUM_PORTS-1:0]             o_hit,
   output logic [NUM_PORTS-1:0][IDX_W-1:0]  o_hit_idx,
   output logic [IDX_W-1:0]                 o_inv_idx,
   output logic                             o_all_valid
);

   logic [NUM_PORTS-1:0][NUM_LINES-1:0] w_match;

   genvar gp, gl;
   generate
      for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
         for (gl = 0; gl < NUM_LINES; gl++) begin : g_line
            assign w_match[gp][gl] = i_valid[gl] && (i_tags[gl] == i_addr[gp]);
         end
      end
   endgenerate

   // Per-port hit encode; scanning downwards lets the lowest index win.
   always_comb begin
      o_hit     = '0;
      o_hit_idx = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (w_match[p][i]) begin
               o_hit[p]     = 1'b1;
               o_hit_idx[p] = IDX_W'(i);
            end
         end
      end
   end

   // Lowest-index invalid entry, used as the preferred victim.
   always_comb begin
      o_inv_idx   = '0;
      o_all_valid = &i_valid;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (!i_valid[i]) o_inv_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/prefetch_line_buffer.sv
// Multi-line fully-associative read-only buffer between fetch and I-cache.
// Zero-wait hits, demand line fill with same-cycle bypass, optional
// next-line prefetch, flush that drains an in-flight fill.
module prefetch_line_buffer
   import prefetch_line_buffer_pkg::*;
#(
   parameter int NUM_LINES   = 4,
   parameter int LINE_BITS   = 256,
   parameter int ADDR_W      = 32,
   parameter int PREFETCH_EN = 1
) (
   input logic                   clk,
   input logic                   rst,
   prefetch_line_buffer_if.slave bus
);

   localparam int OFF_W      = off_w(LINE_BITS);
   localparam int LINE_BYTES = line_bytes(LINE_BITS);
   localparam int WORDS      = LINE_BITS / WORD_W;
   localparam int WSEL_W     = OFF_W - 2;
   localparam int IDX_W      = $clog2(NUM_LINES);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

   // Lookup port assignment in the shared tag matcher.
   localparam int P_UFP  = 0;  // demand address
   localparam int P_FILL = 1;  // line currently being fetched
   localparam int P_NEXT = 2;  // next-line prefetch candidate

   lb_state_t                        r_state;
   logic [ADDR_W-1:0]                r_req_addr;
   logic [ADDR_W-1:0]                r_pf_addr;
   logic [NUM_LINES-1:0]             r_valid;
   logic [NUM_LINES-1:0][ADDR_W-1:0] r_tag;
   logic [LINE_BITS-1:0]             r_data [NUM_LINES];
   logic [IDX_W-1:0]                 r_rr;
   logic                             r_drop;
   logic                             r_dfp_read;
   logic [ADDR_W-1:0]                r_dfp_addr;

   logic                             w_req;
   logic [ADDR_W-1:0]                w_aligned;
   logic [WSEL_W-1:0]                w_word;
   logic [ADDR_W-1:0]                w_fill_addr;
   logic [ADDR_W-1:0]                w_next;
   logic [2:0][ADDR_W-1:0]           w_lk_addr;
   logic [2:0]                       w_lk_hit;
   logic [2:0][IDX_W-1:0]            w_lk_idx;
   logic [IDX_W-1:0]                 w_inv_idx;
   logic                             w_all_valid;
   logic [IDX_W-1:0]                 w_inst_idx;
   logic                             w_nl_resident;
   logic                             w_resp_ok;
   logic                             w_hit;
   logic                             w_bypass;
   logic                             w_resp;
   logic [LINE_BITS-1:0]             w_src_line;
   logic [WORD_W-1:0]                w_word_data;

   assign w_req       = |bus.ufp_rmask;
   assign w_aligned   = bus.ufp_addr & ~OFF_MASK;
   assign w_word      = bus.ufp_addr[OFF_W-1:2];
   assign w_fill_addr = (r_state == PREFETCH) ? r_pf_addr : r_req_addr;
   // Natural ADDR_W-bit overflow gives the wrap from the last line to line 0.
   assign w_next      = r_req_addr + ADDR_W'(LINE_BYTES);

   assign w_lk_addr[P_UFP]  = w_aligned;
   assign w_lk_addr[P_FILL] = w_fill_addr;
   assign w_lk_addr[P_NEXT] = w_next;

   lb_tag_match #(
      .NUM_LINES (NUM_LINES),
      .ADDR_W    (ADDR_W),
      .NUM_PORTS (3),
      .IDX_W     (IDX_W)
   ) u_tag_match (
      .i_valid     (r_valid),
      .i_tags      (r_tag),
      .i_addr      (w_lk_addr),
      .o_hit       (w_lk_hit),
      .o_hit_idx   (w_lk_idx),
      .o_inv_idx   (w_inv_idx),
      .o_all_valid (w_all_valid)
   );

   // A returning line lands on its own entry if somehow already resident
   // (never duplicate a tag), else on the first free entry, else round-robin.
   assign w_inst_idx = w_lk_hit[P_FILL] ? w_lk_idx[P_FILL] :
                       (w_all_valid ? r_rr : w_inv_idx);

   // The next line only counts as resident if this fill is not about to evict it.
   assign w_nl_resident = w_lk_hit[P_NEXT] && (w_lk_idx[P_NEXT] != w_inst_idx);

   // A downstream return is kept only when it was not cancelled by a flush.
   assign w_resp_ok = (r_state != IDLE) && bus.dfp_resp && !r_drop && !bus.flush;

   assign w_hit    = w_req && w_lk_hit[P_UFP] && !bus.flush;
   assign w_bypass = w_resp_ok && w_req && (w_aligned == w_fill_addr);
   assign w_resp   = w_hit || w_bypass;

   assign w_src_line = w_hit ? r_data[w_lk_idx[P_UFP]] : bus.dfp_rdata;

   // Word select within the hit or bypassed line.
   always_comb begin
      w_word_data = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (w_word == WSEL_W'(i)) w_word_data = w_src_line[i*WORD_W +: WORD_W];
      end
   end

   assign bus.ufp_resp  = w_resp;
   assign bus.ufp_rdata = w_resp ? w_word_data : '0;
   assign bus.dfp_read  = r_dfp_read;
   assign bus.dfp_addr  = r_dfp_addr;

   // Line storage: write the returned line and its tag into the chosen entry.
   always_ff @(posedge clk) begin
      if (w_resp_ok) begin
         r_data[w_inst_idx] <= bus.dfp_rdata;
         r_tag[w_inst_idx]  <= w_fill_addr;
      end
   end

   // Control FSM: miss detection, fill/prefetch sequencing, flush drain, RR victim pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_valid    <= '0;
         r_rr       <= '0;
         r_drop     <= 1'b0;
         r_dfp_read <= 1'b0;
         r_dfp_addr <= '0;
         r_req_addr <= '0;
         r_pf_addr  <= '0;
      end else begin
         if (bus.flush) r_valid <= '0;
         case (r_state)
            IDLE: begin
               if (w_req && !w_lk_hit[P_UFP] && !bus.flush) begin
                  r_req_addr <= w_aligned;
                  r_dfp_addr <= w_aligned;
                  r_dfp_read <= 1'b1;
                  r_state    <= FILL;
               end
            end
            FILL, PREFETCH: begin
               // Downstream cannot cancel, so a flush only marks the line for discard.
               if (bus.flush && !bus.dfp_resp) r_drop <= 1'b1;
               if (bus.dfp_resp) begin
                  r_drop <= 1'b0;
                  if (w_resp_ok) begin
                     r_valid[w_inst_idx] <= 1'b1;
                     if (!w_lk_hit[P_FILL] && w_all_valid) r_rr <= r_rr + 1'b1;
                  end
                  if (w_resp_ok && (r_state == FILL) && (PREFETCH_EN != 0) && !w_nl_resident) begin
                     r_pf_addr  <= w_next;
                     r_dfp_addr <= w_next;
                     r_state    <= PREFETCH;
                  end else begin
                     r_dfp_read <= 1'b0;
                     r_dfp_addr <= '0;
                     r_state    <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prefetch_line_buffer.sv
// Directed bench for prefetch_line_buffer: one DUT with prefetch enabled,
// one demand-only DUT for the eviction scenario.
module tb_prefetch_line_buffer;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   prefetch_line_buffer_if #(.ADDR_W(32), .LINE_BITS(256)) bus ();
   prefetch_line_buffer_if #(.ADDR_W(32), .LINE_BITS(256)) bus_np ();

   prefetch_line_buffer #(.NUM_LINES(4), .LINE_BITS(256), .ADDR_W(32), .PREFETCH_EN(1))
      u_dut (.clk(clk), .rst(rst), .bus(bus));

   prefetch_line_buffer #(.NUM_LINES(4), .LINE_BITS(256), .ADDR_W(32), .PREFETCH_EN(0))
      u_dut_np (.clk(clk), .rst(rst), .bus(bus_np));

   // Line whose word i holds its own byte address base+4*i.
   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i * 4);
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush = 1'b0;    bus.ufp_addr = '0;    bus.ufp_rmask = '0;
      bus.dfp_rdata = '0;  bus.dfp_resp = 1'b0;
      bus_np.flush = 1'b0; bus_np.ufp_addr = '0; bus_np.ufp_rmask = '0;
      bus_np.dfp_rdata = '0; bus_np.dfp_resp = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick(); tick(); #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL rst_ufp_resp: got %b want 0", bus.ufp_resp); end
      n_chk++; if (bus.ufp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_ufp_rdata: got %h want 0", bus.ufp_rdata); end
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL rst_dfp_read: got %b want 0", bus.dfp_read); end
      n_chk++; if (bus.dfp_addr !== 32'h0) begin n_fail++; $display("FAIL rst_dfp_addr: got %h want 0", bus.dfp_addr); end
      n_chk++; if (bus_np.dfp_read !== 1'b0) begin n_fail++; $display("FAIL rst_np_dfp_read: got %b want 0", bus_np.dfp_read); end
      rst = 1'b0;
   endtask

   task automatic test_fill_prefetch();
      logic [255:0] line;
      tick(); bus.ufp_addr = 32'h1004; bus.ufp_rmask = 4'hF; #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t1_miss_resp: got %b want 0", bus.ufp_resp); end
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t1_idle_read: got %b want 0", bus.dfp_read); end
      tick(); #1;
      n_chk++; if (bus.dfp_read !== 1'b1) begin n_fail++; $display("FAIL t1_fill_read: got %b want 1", bus.dfp_read); end
      n_chk++; if (bus.dfp_addr !== 32'h1000) begin n_fail++; $display("FAIL t1_fill_addr: got %h want 00001000", bus.dfp_addr); end
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t1_wait_resp: got %b want 0", bus.ufp_resp); end
      tick(); line = mk_line(32'h1000); line[63:32] = 32'hDEADBEEF;
      bus.dfp_rdata = line; bus.dfp_resp = 1'b1; #1;
      n_chk++; if (bus.ufp_resp !== 1'b1) begin n_fail++; $display("FAIL t1_bypass_resp: got %b want 1", bus.ufp_resp); end
      n_chk++; if (bus.ufp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_bypass_data: got %h want deadbeef", bus.ufp_rdata); end
      tick(); bus.dfp_resp = 1'b0; bus.ufp_rmask = 4'h0; #1;
      n_chk++; if (bus.dfp_read !== 1'b1) begin n_fail++; $display("FAIL t1_pf_read: got %b want 1", bus.dfp_read); end
      n_chk++; if (bus.dfp_addr !== 32'h1020) begin n_fail++; $display("FAIL t1_pf_addr: got %h want 00001020", bus.dfp_addr); end
      n_chk++; if (bus.ufp_rdata !== 32'h0) begin n_fail++; $display("FAIL t1_idle_rdata: got %h want 0", bus.ufp_rdata); end
      tick(); bus.dfp_rdata = mk_line(32'h1020); bus.dfp_resp = 1'b1; #1;
      tick(); bus.dfp_resp = 1'b0; #1;
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t1_pf_done_read: got %b want 0", bus.dfp_read); end
      n_chk++; if (bus.dfp_addr !== 32'h0) begin n_fail++; $display("FAIL t1_pf_done_addr: got %h want 0", bus.dfp_addr); end
   endtask

   task automatic test_hits();
      tick(); bus.ufp_addr = 32'h1024; bus.ufp_rmask = 4'hF; #1;
      n_chk++; if (bus.ufp_resp !== 1'b1) begin n_fail++; $display("FAIL t2_pf_hit_resp: got %b want 1", bus.ufp_resp); end
      n_chk++; if (bus.ufp_rdata !== 32'h1024) begin n_fail++; $display("FAIL t2_pf_hit_data: got %h want 00001024", bus.ufp_rdata); end
      tick(); bus.ufp_addr = 32'h1000; #1;
      n_chk++; if (bus.ufp_resp !== 1'b1) begin n_fail++; $display("FAIL t2_hit0_resp: got %b want 1", bus.ufp_resp); end
      n_chk++; if (bus.ufp_rdata !== 32'h1000) begin n_fail++; $display("FAIL t2_hit0_data: got %h want 00001000", bus.ufp_rdata); end
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t2_no_read_a: got %b want 0", bus.dfp_read); end
      tick(); bus.ufp_addr = 32'h103F; #1;
      n_chk++; if (bus.ufp_rdata !== 32'h103C) begin n_fail++; $display("FAIL t2_last_word: got %h want 0000103c", bus.ufp_rdata); end
      tick(); bus.ufp_rmask = 4'h0; #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t2_nomask_resp: got %b want 0", bus.ufp_resp); end
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t2_no_read_b: got %b want 0", bus.dfp_read); end
   endtask

   task automatic test_flush();
      tick(); bus.ufp_addr = 32'h1004; bus.ufp_rmask = 4'hF; bus.flush = 1'b1; #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t4_flush_hit_supp: got %b want 0", bus.ufp_resp); end
      tick(); bus.flush = 1'b0; bus.ufp_rmask = 4'h0; #1;
      tick(); bus.ufp_addr = 32'h2008; bus.ufp_rmask = 4'hF; #1;
      tick(); #1;
      n_chk++; if (bus.dfp_addr !== 32'h2000) begin n_fail++; $display("FAIL t4_fill_addr: got %h want 00002000", bus.dfp_addr); end
      tick(); bus.flush = 1'b1; #1;
      tick(); bus.flush = 1'b0; #1;
      n_chk++; if (bus.dfp_read !== 1'b1) begin n_fail++; $display("FAIL t4_read_held: got %b want 1", bus.dfp_read); end
      tick(); #1;
      tick(); bus.dfp_rdata = mk_line(32'h2000); bus.dfp_resp = 1'b1; #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t4_dropped_resp: got %b want 0", bus.ufp_resp); end
      tick(); bus.dfp_resp = 1'b0; #1;
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t4_back_idle: got %b want 0", bus.dfp_read); end
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t4_still_miss: got %b want 0", bus.ufp_resp); end
      tick(); #1;
      n_chk++; if (bus.dfp_addr !== 32'h2000) begin n_fail++; $display("FAIL t4_rerequest: got %h want 00002000", bus.dfp_addr); end
      tick(); bus.dfp_rdata = mk_line(32'h2000); bus.dfp_resp = 1'b1; #1;
      n_chk++; if (bus.ufp_rdata !== 32'h2008) begin n_fail++; $display("FAIL t4_refill_data: got %h want 00002008", bus.ufp_rdata); end
      tick(); bus.dfp_resp = 1'b0; bus.ufp_addr = 32'h1004; #1;
      n_chk++; if (bus.dfp_addr !== 32'h2020) begin n_fail++; $display("FAIL t4_pf_addr: got %h want 00002020", bus.dfp_addr); end
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t4_old_line_flushed: got %b want 0", bus.ufp_resp); end
      tick(); bus.dfp_rdata = mk_line(32'h2020); bus.dfp_resp = 1'b1; #1;
      tick(); bus.dfp_resp = 1'b0; bus.ufp_rmask = 4'h0; #1;
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t4_end_idle: got %b want 0", bus.dfp_read); end
   endtask

   task automatic test_stall_during_prefetch();
      tick(); bus.ufp_addr = 32'h3804; bus.ufp_rmask = 4'hF; #1;
      tick(); #1;
      tick(); bus.dfp_rdata = mk_line(32'h3800); bus.dfp_resp = 1'b1; #1;
      n_chk++; if (bus.ufp_rdata !== 32'h3804) begin n_fail++; $display("FAIL t5_fill_data: got %h want 00003804", bus.ufp_rdata); end
      tick(); bus.dfp_resp = 1'b0; bus.ufp_addr = 32'h3808; #1;
      n_chk++; if (bus.dfp_addr !== 32'h3820) begin n_fail++; $display("FAIL t5_pf_addr: got %h want 00003820", bus.dfp_addr); end
      n_chk++; if (bus.ufp_rdata !== 32'h3808) begin n_fail++; $display("FAIL t5_hit_in_pf: got %h want 00003808", bus.ufp_rdata); end
      tick(); bus.ufp_addr = 32'h3000; #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t5_stall_a: got %b want 0", bus.ufp_resp); end
      tick(); #1;
      n_chk++; if (bus.dfp_addr !== 32'h3820) begin n_fail++; $display("FAIL t5_pf_held: got %h want 00003820", bus.dfp_addr); end
      tick(); bus.dfp_rdata = mk_line(32'h3820); bus.dfp_resp = 1'b1; #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t5_stall_b: got %b want 0", bus.ufp_resp); end
      tick(); bus.dfp_resp = 1'b0; #1;
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t5_idle_after_pf: got %b want 0", bus.dfp_read); end
      tick(); #1;
      n_chk++; if (bus.dfp_read !== 1'b1) begin n_fail++; $display("FAIL t5_fill_read: got %b want 1", bus.dfp_read); end
      n_chk++; if (bus.dfp_addr !== 32'h3000) begin n_fail++; $display("FAIL t5_fill_addr: got %h want 00003000", bus.dfp_addr); end
      tick(); bus.dfp_rdata = mk_line(32'h3000); bus.dfp_resp = 1'b1; #1;
      n_chk++; if (bus.ufp_rdata !== 32'h3000) begin n_fail++; $display("FAIL t5_fill_data2: got %h want 00003000", bus.ufp_rdata); end
      tick(); bus.dfp_resp = 1'b0; bus.ufp_rmask = 4'h0; #1;
      n_chk++; if (bus.dfp_addr !== 32'h3020) begin n_fail++; $display("FAIL t5_pf2_addr: got %h want 00003020", bus.dfp_addr); end
      tick(); bus.dfp_rdata = mk_line(32'h3020); bus.dfp_resp = 1'b1; #1;
      tick(); bus.dfp_resp = 1'b0; #1;
   endtask

   task automatic test_eviction();
      logic [31:0] a;
      for (int n = 0; n < 5; n++) begin
         a = 32'h8000 + 32'(n * 32);
         tick(); bus_np.ufp_addr = a + 32'h4; bus_np.ufp_rmask = 4'hF; #1;
         n_chk++; if (bus_np.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t3_miss[%0d]: got %b want 0", n, bus_np.ufp_resp); end
         tick(); #1;
         n_chk++; if (bus_np.dfp_addr !== a) begin n_fail++; $display("FAIL t3_fill_addr[%0d]: got %h want %h", n, bus_np.dfp_addr, a); end
         tick(); bus_np.dfp_rdata = mk_line(a); bus_np.dfp_resp = 1'b1; #1;
         n_chk++; if (bus_np.ufp_rdata !== a + 32'h4) begin n_fail++; $display("FAIL t3_data[%0d]: got %h want %h", n, bus_np.ufp_rdata, a + 32'h4); end
         tick(); bus_np.dfp_resp = 1'b0; bus_np.ufp_rmask = 4'h0; #1;
         n_chk++; if (bus_np.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t3_no_prefetch[%0d]: got %b want 0", n, bus_np.dfp_read); end
      end
      tick(); bus_np.ufp_addr = 32'h8048; bus_np.ufp_rmask = 4'hF; #1;
      n_chk++; if (bus_np.ufp_rdata !== 32'h8048) begin n_fail++; $display("FAIL t3_kept_hit: got %h want 00008048", bus_np.ufp_rdata); end
      tick(); bus_np.ufp_addr = 32'h8004; #1;
      n_chk++; if (bus_np.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t3_evicted_miss: got %b want 0", bus_np.ufp_resp); end
      tick(); #1;
      n_chk++; if (bus_np.dfp_addr !== 32'h8000) begin n_fail++; $display("FAIL t3_refetch: got %h want 00008000", bus_np.dfp_addr); end
      tick(); bus_np.dfp_rdata = mk_line(32'h8000); bus_np.dfp_resp = 1'b1; #1;
      tick(); bus_np.dfp_resp = 1'b0; bus_np.ufp_addr = 32'h8084; #1;
      n_chk++; if (bus_np.ufp_rdata !== 32'h8084) begin n_fail++; $display("FAIL t3_fifth_hit: got %h want 00008084", bus_np.ufp_rdata); end
      tick(); bus_np.ufp_addr = 32'h8024; #1;
      n_chk++; if (bus_np.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t3_rr_second_victim: got %b want 0", bus_np.ufp_resp); end
      tick(); bus_np.ufp_rmask = 4'h0; #1;
   endtask

   task automatic test_wrap_and_reset();
      tick(); bus.ufp_addr = 32'hFFFF_FFE4; bus.ufp_rmask = 4'hF; #1;
      tick(); #1;
      n_chk++; if (bus.dfp_addr !== 32'hFFFF_FFE0) begin n_fail++; $display("FAIL t6_fill_addr: got %h want ffffffe0", bus.dfp_addr); end
      tick(); bus.dfp_rdata = mk_line(32'hFFFF_FFE0); bus.dfp_resp = 1'b1; #1;
      n_chk++; if (bus.ufp_rdata !== 32'hFFFF_FFE4) begin n_fail++; $display("FAIL t6_fill_data: got %h want ffffffe4", bus.ufp_rdata); end
      tick(); bus.dfp_resp = 1'b0; bus.ufp_rmask = 4'h0; #1;
      n_chk++; if (bus.dfp_read !== 1'b1) begin n_fail++; $display("FAIL t6_wrap_read: got %b want 1", bus.dfp_read); end
      n_chk++; if (bus.dfp_addr !== 32'h0) begin n_fail++; $display("FAIL t6_wrap_addr: got %h want 00000000", bus.dfp_addr); end
      tick(); bus.dfp_rdata = mk_line(32'h0); bus.dfp_resp = 1'b1; #1;
      tick(); bus.dfp_resp = 1'b0; bus.ufp_addr = 32'h5004; bus.ufp_rmask = 4'hF; #1;
      tick(); #1;
      n_chk++; if (bus.dfp_addr !== 32'h5000) begin n_fail++; $display("FAIL t6_midfill_addr: got %h want 00005000", bus.dfp_addr); end
      tick(); rst = 1'b1; bus.ufp_rmask = 4'h0; #1;
      tick(); #1;
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t6_rst_read: got %b want 0", bus.dfp_read); end
      n_chk++; if (bus.dfp_addr !== 32'h0) begin n_fail++; $display("FAIL t6_rst_addr: got %h want 0", bus.dfp_addr); end
      n_chk++; if (bus.ufp_rdata !== 32'h0) begin n_fail++; $display("FAIL t6_rst_rdata: got %h want 0", bus.ufp_rdata); end
      tick(); rst = 1'b0; bus.dfp_rdata = mk_line(32'h5000); bus.dfp_resp = 1'b1; #1;
      tick(); bus.dfp_resp = 1'b0; #1;
      n_chk++; if (bus.dfp_read !== 1'b0) begin n_fail++; $display("FAIL t6_stray_ignored: got %b want 0", bus.dfp_read); end
      tick(); bus.ufp_addr = 32'h5004; bus.ufp_rmask = 4'hF; #1;
      n_chk++; if (bus.ufp_resp !== 1'b0) begin n_fail++; $display("FAIL t6_stray_not_installed: got %b want 0", bus.ufp_resp); end
      tick(); bus.ufp_rmask = 4'h0; #1;
   endtask

   // Hard stop in case the sequence ever hangs on a clock edge.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill_prefetch();
      test_hits();
      test_flush();
      test_stall_during_prefetch();
      test_eviction();
      test_wrap_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
